// File: rtl/ps2_tron_keys_pkg.sv
// rtl/ps2_tron_keys_pkg.sv - shared constants for the Tron PS/2 key decoder
package ps2_tron_keys_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_W      = 8'h1D;
  localparam logic [7:0] SC_A      = 8'h1C;
  localparam logic [7:0] SC_S      = 8'h1B;
  localparam logic [7:0] SC_D      = 8'h23;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;

  localparam int         NUM_KEYS  = 9;
  localparam logic [3:0] KEY_W     = 4'd0;
  localparam logic [3:0] KEY_A     = 4'd1;
  localparam logic [3:0] KEY_S     = 4'd2;
  localparam logic [3:0] KEY_D     = 4'd3;
  localparam logic [3:0] KEY_UP    = 4'd4;
  localparam logic [3:0] KEY_DOWN  = 4'd5;
  localparam logic [3:0] KEY_LEFT  = 4'd6;
  localparam logic [3:0] KEY_RIGHT = 4'd7;
  localparam logic [3:0] KEY_ENTER = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } prefix_state_t;

  function automatic logic [1:0] opposite(input logic [1:0] d);
    return d ^ 2'd2;
  endfunction

endpackage

// File: rtl/ps2_tron_keys.sv
// rtl/ps2_tron_keys.sv - PS/2 scancode decoder producing held keys and player directions
module ps2_tron_keys
  import ps2_tron_keys_pkg::*;
#(
  parameter logic [1:0] P1_INIT_DIR = 2'd1,
  parameter logic [1:0] P2_INIT_DIR = 2'd3
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [7:0]          received_data,
  input  logic                received_data_en,
  input  logic                dir_init,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [1:0]          p1_dir,
  output logic [1:0]          p2_dir,
  output logic                start_pulse
);

  prefix_state_t       state, state_next;
  logic                dec_valid, dec_ext, dec_brk;
  logic                hit, new_press;
  logic [3:0]          key_idx;
  logic [1:0]          req_dir;
  logic [NUM_KEYS-1:0] key_state_next;
  logic [1:0]          p1_dir_next, p2_dir_next;
  logic                start_next;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= ST_IDLE;
      key_state   <= '0;
      p1_dir      <= P1_INIT_DIR;
      p2_dir      <= P2_INIT_DIR;
      start_pulse <= 1'b0;
    end else begin
      state       <= state_next;
      key_state   <= key_state_next;
      p1_dir      <= p1_dir_next;
      p2_dir      <= p2_dir_next;
      start_pulse <= start_next;
    end
  end

  // Prefix tracking: only a non-prefix byte yields a decode strobe.
  always_comb begin
    state_next = state;
    dec_valid  = 1'b0;
    dec_ext    = 1'b0;
    dec_brk    = 1'b0;
    if (received_data_en) begin
      case (state)
        ST_IDLE: begin
          if (received_data == SC_E0)      state_next = ST_EXT;
          else if (received_data == SC_F0) state_next = ST_BRK;
          else                             dec_valid  = 1'b1;
        end
        ST_EXT: begin
          if (received_data == SC_F0)      state_next = ST_EXT_BRK;
          else if (received_data == SC_E0) state_next = ST_EXT;
          else begin
            state_next = ST_IDLE;
            dec_valid  = 1'b1;
            dec_ext    = 1'b1;
          end
        end
        ST_BRK: begin
          state_next = ST_IDLE;
          if (received_data != SC_E0 && received_data != SC_F0) begin
            dec_valid = 1'b1;
            dec_brk   = 1'b1;
          end
        end
        default: begin
          state_next = ST_IDLE;
          dec_valid  = 1'b1;
          dec_ext    = 1'b1;
          dec_brk    = 1'b1;
        end
      endcase
    end
  end

  // Key table: keypad codes share bytes with arrows/enter, so the E0 flag must match.
  always_comb begin
    hit     = 1'b0;
    key_idx = KEY_W;
    req_dir = DIR_UP;
    if (dec_valid) begin
      if (dec_ext) begin
        case (received_data)
          SC_UP:    begin hit = 1'b1; key_idx = KEY_UP;    req_dir = DIR_UP;    end
          SC_DOWN:  begin hit = 1'b1; key_idx = KEY_DOWN;  req_dir = DIR_DOWN;  end
          SC_LEFT:  begin hit = 1'b1; key_idx = KEY_LEFT;  req_dir = DIR_LEFT;  end
          SC_RIGHT: begin hit = 1'b1; key_idx = KEY_RIGHT; req_dir = DIR_RIGHT; end
          default:  hit = 1'b0;
        endcase
      end else begin
        case (received_data)
          SC_W:     begin hit = 1'b1; key_idx = KEY_W;     req_dir = DIR_UP;    end
          SC_A:     begin hit = 1'b1; key_idx = KEY_A;     req_dir = DIR_LEFT;  end
          SC_S:     begin hit = 1'b1; key_idx = KEY_S;     req_dir = DIR_DOWN;  end
          SC_D:     begin hit = 1'b1; key_idx = KEY_D;     req_dir = DIR_RIGHT; end
          SC_ENTER: begin hit = 1'b1; key_idx = KEY_ENTER; end
          default:  hit = 1'b0;
        endcase
      end
    end
  end

  // Typematic repeats leave the bit set, so only a 0->1 edge counts as a press.
  always_comb begin
    key_state_next = key_state;
    new_press      = hit && !dec_brk && !key_state[key_idx];
    if (hit) key_state_next[key_idx] = !dec_brk;

    p1_dir_next = p1_dir;
    p2_dir_next = p2_dir;
    if (dir_init) begin
      p1_dir_next = P1_INIT_DIR;
      p2_dir_next = P2_INIT_DIR;
    end else if (new_press) begin
      if (key_idx <= KEY_D) begin
        if (req_dir != opposite(p1_dir)) p1_dir_next = req_dir;
      end else if (key_idx <= KEY_RIGHT) begin
        if (req_dir != opposite(p2_dir)) p2_dir_next = req_dir;
      end
    end

    start_next = new_press && (key_idx == KEY_ENTER);
  end

endmodule

// File: doc/ps2_tron_keys.md
# ps2_tron_keys

Decodes the raw PS/2 scancode byte stream from `PS2_Controller` (`received_data`/`received_data_en`) into held-key levels and per-player direction registers for the Tron game logic. Handles the `E0` extended prefix and the `F0` break prefix, so key releases and arrow keys are tracked correctly instead of "last byte seen". Sits between `PS2_Controller` and the game FSM.

## Interface
- `P1_INIT_DIR`, default 2'd1 (RIGHT): player-1 direction after reset or `dir_init`.
- `P2_INIT_DIR`, default 2'd3 (LEFT): player-2 direction after reset or `dir_init`.

- `CLOCK_50`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `received_data`  in  8  scancode byte from `PS2_Controller`.
- `received_data_en`  in  1  one-cycle strobe; `received_data` valid.
- `dir_init`  in  1  one-cycle pulse at round start; reloads both init directions.
- `key_state`  out  9  held levels: [0]w [1]a [2]s [3]d [4]up [5]down [6]left [7]right [8]enter.
- `p1_dir`  out  2  player-1 direction (WASD).
- `p2_dir`  out  2  player-2 direction (arrows).
- `start_pulse`  out  1  one-cycle pulse on enter press (not repeat).

## Operation
- Direction encoding: UP=0, RIGHT=1, DOWN=2, LEFT=3; opposite(d) = d ^ 2.
- Key codes: plain w=1D, a=1C, s=1B, d=23, enter=5A; extended (after E0) up=75, down=72, left=6B, right=74. E0 5A (keypad enter) and plain 75/72/6B/74 (keypad digits) are not matched.
- Prefix FSM, advances only on `received_data_en`:
  - IDLE: E0→EXT; F0→BRK; else decode as plain make → IDLE.
  - EXT: F0→EXT_BRK; E0→EXT; else decode as extended make → IDLE.
  - BRK: decode as plain break → IDLE (E0/F0 here → IDLE, no decode).
  - EXT_BRK: decode as extended break → IDLE.
  - All other bytes (FA, AA, E1 sequences, unknown codes) produce no effect.
- Make of matched key: set its `key_state` bit. Break: clear it.
- Typematic repeat (make while bit already set): no new event; `start_pulse` and direction changes fire only on 0→1 of the bit.
- Direction update on a new WASD (p1) or arrow (p2) press: load requested direction unless it equals opposite(current); equal to current is a no-op.
- `dir_init` reloads `p1_dir`/`p2_dir` with the init parameters; `key_state` untouched.

## Timing
- All outputs registered. Byte accepted at edge t (strobe high) → `key_state`, dirs, `start_pulse` reflect it after edge t+1 (1-cycle latency).
- `start_pulse` high exactly one cycle.
- Reset values: FSM=IDLE, `key_state`=0, `p1_dir`=`P1_INIT_DIR`, `p2_dir`=`P2_INIT_DIR`, `start_pulse`=0.
- `reset` mid-sequence (e.g. after E0) discards the prefix; next byte is decoded from IDLE.
- `dir_init` and a direction press in the same cycle: `dir_init` wins; the press still sets `key_state`.
- Both players' presses cannot coincide (one byte per strobe); no arbitration needed.
- No back-pressure; strobes may arrive on consecutive cycles.

## Structure
- Shared package: direction encoding constants (UP/RIGHT/DOWN/LEFT), scancode constants (E0, F0, the nine key codes), `key_state` bit indices.
- One sub-module natural: `ps2_prefix_fsm` (owns the 4-state prefix FSM, outputs decoded `{code, extended, brk, valid}` one cycle later); top handles key table and direction logic, adding 1 cycle — total latency then 2, so it is to be kept inline unless latency is updated here.

## Test plan
- Reset, feed 1D → `key_state[0]`=1, `p1_dir`=0 (UP); feed F0 1D → `key_state[0]`=0, `p1_dir` stays 0.
- From reset (`p2_dir`=3), feed E0 74 (right) → `p2_dir` stays 3 (reverse blocked); feed E0 75 → `p2_dir`=0; feed E0 F0 75 → `key_state[4]`=0.
- Feed 5A, 5A, 5A (typematic) → `start_pulse` high exactly once, one cycle; F0 5A then 5A → second pulse.
- Feed 75 without E0 → no change; feed E0 5A → `key_state[8]` stays 0, no pulse.
- Feed E0, assert `reset`, then 75 → no effect, `p2_dir`=3; feed FA, AA → no effect.
- Set `p1_dir`=0 via 1D, then pulse `dir_init` in same cycle as 23 strobe → `p1_dir`=1, `key_state[3]`=1.
